// File: rtl/prefix_carry_pipeline.sv
// ---------------------------------------------------------------------------
// prefix_carry_pipeline
//
// Pipelined Kogge-Stone carry network. It takes the bitwise generate/propagate
// vectors from a PG stage and produces Sum and Cout.
//
// Bit 0 of the vectors is the carry-in slot: G[0]=Cin and P[0]=0. Each prefix
// level (distance 1, 2, 4, ...) is followed by a register stage, so the block
// has LEVELS stages.
//
// The stages are connected by an elastic valid/ready chain. It sustains one
// add per cycle, and a stage that holds a bubble can take new data while the
// output is stalled.
//
// Optional feature:
//   PREFIX_CARRY_OVF_EN adds the Ovf output, the two's-complement overflow of
//   the final carries.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   G/P valid this cycle
//   in_ready   stage 0 can accept this cycle
//   G [W:0]    bitwise generate, G[0] = carry-in
//   P [W:0]    bitwise propagate, P[0] = 0
//   out_valid  Sum/Cout valid
//   out_ready  downstream accepts this cycle
//   Sum[W-1:0] sum bits (vector positions W..1)
//   Cout       carry out of position W
//   Ovf        signed overflow (only with PREFIX_CARRY_OVF_EN)
// ---------------------------------------------------------------------------
module prefix_carry_pipeline #(
  parameter  int WIDTH  = 16,
  localparam int LEVELS = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   G,
  input  logic [WIDTH:0]   P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef PREFIX_CARRY_OVF_EN
  ,
  output logic             Ovf
`endif
);

  // Per-stage state. Row k of each array holds the registered result of
  // prefix level k.
  logic [LEVELS-1:0]              valid_q;
  logic [LEVELS-1:0]              stage_ready;
  logic [LEVELS-1:0]              up_valid;
  logic [LEVELS-1:0][WIDTH:0]     g_q;
  logic [LEVELS-1:0][WIDTH:0]     p_q;
  logic [LEVELS-1:0][WIDTH:0]     g_d;
  logic [LEVELS-1:0][WIDTH:0]     p_d;
  logic [LEVELS-1:0][WIDTH:0]     g_src;
  logic [LEVELS-1:0][WIDTH:0]     p_src;
  logic [LEVELS-1:0][WIDTH-1:0]   pbit_q;
  logic [LEVELS-1:0][WIDTH-1:0]   pbit_src;
  logic                           ready_acc;
  logic [WIDTH:0]                 carry;
  logic                           unused_p_last;

  // Ready chain. A stage is ready when it is empty or when everything
  // downstream can move. The chain is evaluated from the output backwards,
  // so a bubble anywhere downstream lets all the stages above it advance.
  always_comb begin
    stage_ready = '0;
    ready_acc   = out_ready;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      ready_acc      = ready_acc | ~valid_q[k];
      stage_ready[k] = ready_acc;
    end
  end

  assign in_ready = stage_ready[0];

  // Prefix levels. Level gi combines each position with the one 2^gi below
  // it. Positions below the distance pass through unchanged.
  genvar gi, gj;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      localparam int DIST = 1 << gi;

      if (gi == 0) begin : g_src_in
        assign up_valid[gi] = in_valid;
        assign g_src[gi]    = G;
        assign p_src[gi]    = P;
        assign pbit_src[gi] = P[WIDTH:1];
      end else begin : g_src_prev
        assign up_valid[gi] = valid_q[gi-1];
        assign g_src[gi]    = g_q[gi-1];
        assign p_src[gi]    = p_q[gi-1];
        assign pbit_src[gi] = pbit_q[gi-1];
      end

      for (gj = 0; gj <= WIDTH; gj++) begin : g_bit
        if (gj >= DIST) begin : g_combine
          assign g_d[gi][gj] = g_src[gi][gj] | (p_src[gi][gj] & g_src[gi][gj-DIST]);
          assign p_d[gi][gj] = p_src[gi][gj] & p_src[gi][gj-DIST];
        end else begin : g_pass
          assign g_d[gi][gj] = g_src[gi][gj];
          assign p_d[gi][gj] = p_src[gi][gj];
        end
      end
    end
  endgenerate

  // Stage registers. A stage takes its upstream valid whenever it is ready.
  // Its data is captured only when that upstream valid is set, so a bubble
  // moving through never overwrites the data it replaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      g_q     <= '0;
      p_q     <= '0;
      pbit_q  <= '0;
    end else begin
      for (int k = 0; k < LEVELS; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= up_valid[k];
          if (up_valid[k]) begin
            g_q[k]    <= g_d[k];
            p_q[k]    <= p_d[k];
            pbit_q[k] <= pbit_src[k];
          end
        end
      end
    end
  end

  // After the last level, the group generate at position i is the carry out
  // of position i. The group propagate of the final level has no consumer.
  assign carry         = g_q[LEVELS-1];
  assign unused_p_last = ^p_q[LEVELS-1];

  assign out_valid = valid_q[LEVELS-1];
  assign Sum       = pbit_q[LEVELS-1] ^ carry[WIDTH-1:0];
  assign Cout      = carry[WIDTH];

`ifdef PREFIX_CARRY_OVF_EN
  // Overflow: the carry into the MSB differs from the carry out of it.
  assign Ovf = carry[WIDTH] ^ carry[WIDTH-1];
`endif

endmodule
